// File: rtl/i2c_write_ctrl.sv
// Single-master I2C write sequencer: START, 7-bit address + W, ACK, one data byte, ACK, STOP.
// SCL timing derived from ref_clk; DELAY ref_clk cycles per SCL period.
module i2c_write_ctrl #(
    parameter int unsigned DELAY = 250
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int unsigned QTR = DELAY / 4;
    // Odd phases absorb any remainder so each SCL half stays DELAY/2 even if DELAY%4 != 0.
    localparam int unsigned PH1 = DELAY / 2 - QTR;
    localparam int unsigned PH3 = (DELAY - DELAY / 2) - QTR;
    localparam int unsigned QW  = $clog2(DELAY);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAck1,
        StData,
        StAck2,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            ack_err_q, ack_err_d;
    logic            done_q, done_d;
    logic [QW-1:0]   qlim;
    logic            q_wrap, slot_end, ack_sample;

    always_comb begin
        unique case (phase_q)
            2'd1:    qlim = QW'(PH1 - 1);
            2'd3:    qlim = QW'(PH3 - 1);
            default: qlim = QW'(QTR - 1);
        endcase
    end

    assign q_wrap     = (qcnt_q == qlim);
    assign slot_end   = q_wrap && (phase_q == 2'd3);
    assign ack_sample = ((state_q == StAck1) || (state_q == StAck2)) &&
                        (phase_q == 2'd3) && (qcnt_q == '0);

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q == StIdle) begin
            qcnt_d  = '0;
            phase_d = 2'd0;
            // The done cycle itself never accepts, so a held start restarts one cycle later.
            if (start && !done_q) begin
                state_d   = StStart;
                shift_d   = {addr, 1'b0};
                data_d    = data;
                bit_d     = 3'd7;
                ack_err_d = 1'b0;
            end
        end else begin
            qcnt_d = q_wrap ? '0 : qcnt_q + QW'(1);
            if (q_wrap) begin
                phase_d = phase_q + 2'd1;
            end
            if (ack_sample && sda_in) begin
                ack_err_d = 1'b1;
            end
            if (slot_end) begin
                unique case (state_q)
                    StStart: state_d = StAddr;
                    StAddr, StData: begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                        if (bit_q == 3'd0) begin
                            state_d = (state_q == StAddr) ? StAck1 : StAck2;
                        end
                    end
                    StAck1: begin
                        if (ack_err_q) begin
                            state_d = StStop;
                        end else begin
                            state_d = StData;
                            shift_d = data_q;
                            bit_d   = 3'd7;
                        end
                    end
                    StAck2: state_d = StStop;
                    StStop: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd7;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StStart: sda_oe = phase_q[1];
            StAddr, StData: begin
                scl    = phase_q[1];
                sda_oe = ~shift_q[7];
            end
            StAck1, StAck2: scl = phase_q[1];
            StStop: begin
                scl    = phase_q[1];
                sda_oe = (phase_q != 2'd3);
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_write_ctrl.sv
// Directed self-checking bench for i2c_write_ctrl: DELAY=8 instance for function, DELAY=250 for timing.
module tb_i2c_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, sda_in_a, scl_a, sda_oe_a, busy_a, done_a, ack_err_a;
    logic [6:0] addr_a;
    logic [7:0] data_a;
    logic       start_b, sda_in_b, scl_b, sda_oe_b, busy_b, done_b, ack_err_b;
    logic [6:0] addr_b;
    logic [7:0] data_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i2c_write_ctrl #(.DELAY(8)) u_dut_a (
        .ref_clk(clk), .reset(rst), .start(start_a), .addr(addr_a), .data(data_a),
        .sda_in(sda_in_a), .scl(scl_a), .sda_oe(sda_oe_a), .busy(busy_a), .done(done_a),
        .ack_err(ack_err_a)
    );

    i2c_write_ctrl #(.DELAY(250)) u_dut_b (
        .ref_clk(clk), .reset(rst), .start(start_b), .addr(addr_b), .data(data_b),
        .sda_in(sda_in_b), .scl(scl_b), .sda_oe(sda_oe_b), .busy(busy_b), .done(done_b),
        .ack_err(ack_err_b)
    );

    // Launches one transaction on DUT a and observes it from the cycle after acceptance to done.
    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic n1,
                           input logic n2, input bit repulse, input bit hold,
                           output int busy_cyc, output int done_cnt, output int rises,
                           output logic [7:0] abits, output logic [7:0] dbits,
                           output int starts, output int stops, output bit timeout);
        logic pscl, poe;
        busy_cyc = 0; done_cnt = 0; rises = 0; abits = '0; dbits = '0;
        starts = 0; stops = 0; timeout = 1'b1;
        @(negedge clk);
        addr_a = a; data_a = d; start_a = 1'b1; sda_in_a = n1;
        pscl = scl_a; poe = sda_oe_a;
        @(negedge clk);
        if (!hold) start_a = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (busy_a) busy_cyc++;
            if (done_a) done_cnt++;
            if (!pscl && scl_a) begin
                rises++;
                if (rises <= 8) abits = {abits[6:0], ~sda_oe_a};
                else if (rises >= 10 && rises <= 17) dbits = {dbits[6:0], ~sda_oe_a};
            end
            if (pscl && scl_a && (poe != sda_oe_a)) begin
                if (sda_oe_a) starts++;
                else stops++;
            end
            pscl = scl_a; poe = sda_oe_a;
            sda_in_a = (rises >= 10) ? n2 : n1;
            if (repulse && c == 40) begin
                start_a = 1'b1; addr_a = ~a; data_a = ~d;
            end
            if (repulse && c == 41) start_a = 1'b0;
            if (done_a) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done_a(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL %s: done seen=%0b expected 1", name, seen); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (scl_a !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b expected 1", scl_a); end
        if (sda_oe_a !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
        if (ack_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", ack_err_a); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_write();
        int bc, dc, r, s, p; logic [7:0] ab, db; bit to;
        run_txn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, bc, dc, r, ab, db, s, p, to);
        n_cmp += 9;
        if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b expected 0", to); end
        if (ab !== 8'hA0) begin n_fail++; $display("FAIL full_addr_bits: got %h expected a0", ab); end
        if (db !== 8'hA5) begin n_fail++; $display("FAIL full_data_bits: got %h expected a5", db); end
        if (r !== 19) begin n_fail++; $display("FAIL full_scl_rises: got %0d expected 19", r); end
        if (s !== 1 || p !== 1) begin n_fail++; $display("FAIL full_start_stop: got %0d/%0d expected 1/1", s, p); end
        if (bc !== 160) begin n_fail++; $display("FAIL full_busy_cycles: got %0d expected 160", bc); end
        if (dc !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", dc); end
        if (ack_err_a !== 1'b0) begin n_fail++; $display("FAIL full_ack_err: got %b expected 0", ack_err_a); end
        @(negedge clk);
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL full_done_width: got %b expected 0", done_a); end
    endtask

    task automatic test_addr_nack();
        int bc, dc, r, s, p; logic [7:0] ab, db; bit to;
        run_txn(7'h3C, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, bc, dc, r, ab, db, s, p, to);
        n_cmp += 7;
        if (to !== 1'b0) begin n_fail++; $display("FAIL anack_timeout: got %b expected 0", to); end
        if (ab !== 8'h78) begin n_fail++; $display("FAIL anack_addr_bits: got %h expected 78", ab); end
        if (r !== 10) begin n_fail++; $display("FAIL anack_scl_rises: got %0d expected 10", r); end
        if (s !== 1 || p !== 1) begin n_fail++; $display("FAIL anack_start_stop: got %0d/%0d expected 1/1", s, p); end
        if (bc !== 88) begin n_fail++; $display("FAIL anack_busy_cycles: got %0d expected 88", bc); end
        if (dc !== 1) begin n_fail++; $display("FAIL anack_done_count: got %0d expected 1", dc); end
        if (ack_err_a !== 1'b1) begin n_fail++; $display("FAIL anack_ack_err: got %b expected 1", ack_err_a); end
    endtask

    task automatic test_data_nack();
        int bc, dc, r, s, p; logic [7:0] ab, db; bit to;
        run_txn(7'h11, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, bc, dc, r, ab, db, s, p, to);
        n_cmp += 4;
        if (bc !== 160) begin n_fail++; $display("FAIL dnack_busy_cycles: got %0d expected 160", bc); end
        if (db !== 8'hC3) begin n_fail++; $display("FAIL dnack_data_bits: got %h expected c3", db); end
        if (ack_err_a !== 1'b1) begin n_fail++; $display("FAIL dnack_ack_err: got %b expected 1", ack_err_a); end
        @(negedge clk);
        sda_in_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        if (ack_err_a !== 1'b0) begin n_fail++; $display("FAIL dnack_clear: got %b expected 0", ack_err_a); end
        wait_done_a("dnack_followup_done");
    endtask

    task automatic test_reset_mid_data();
        int dones = 0;
        @(negedge clk);
        addr_a = 7'h22; data_a = 8'h0F; sda_in_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 5;
        if (scl_a !== 1'b1) begin n_fail++; $display("FAIL midrst_scl: got %b expected 1", scl_a); end
        if (sda_oe_a !== 1'b0) begin n_fail++; $display("FAIL midrst_sda_oe: got %b expected 0", sda_oe_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
        for (int c = 0; c < 20; c++) begin
            if (done_a) dones++;
            @(negedge clk);
        end
        if (dones !== 0) begin n_fail++; $display("FAIL midrst_done: got %0d expected 0", dones); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %b expected 0", busy_a); end
    endtask

    task automatic test_repulse();
        int bc, dc, r, s, p; logic [7:0] ab, db; bit to;
        run_txn(7'h2B, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, bc, dc, r, ab, db, s, p, to);
        n_cmp += 3;
        if (ab !== 8'h56) begin n_fail++; $display("FAIL repulse_addr_bits: got %h expected 56", ab); end
        if (db !== 8'h3C) begin n_fail++; $display("FAIL repulse_data_bits: got %h expected 3c", db); end
        if (bc !== 160) begin n_fail++; $display("FAIL repulse_busy_cycles: got %0d expected 160", bc); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc, dc, r, s, p; logic [7:0] ab, db; bit to;
        run_txn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, bc, dc, r, ab, db, s, p, to);
        n_cmp += 4;
        if (bc !== 160) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 160", bc); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_at_done: got %b expected 0", busy_a); end
        @(negedge clk);
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_cycle: got %b expected 0", busy_a); end
        @(negedge clk);
        start_a = 1'b0;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy_a); end
        wait_done_a("b2b_second_done");
    endtask

    task automatic test_timing_250();
        int runlen = 0, nruns = 0, starts = 0, stops = 0, bc = 0;
        int lens[4];
        bit fell = 1'b0, seen = 1'b0;
        logic pscl, poe;
        for (int i = 0; i < 4; i++) lens[i] = 0;
        @(negedge clk);
        addr_b = 7'h50; data_b = 8'hA5; sda_in_b = 1'b0; start_b = 1'b1;
        pscl = scl_b; poe = sda_oe_b;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 6000 && !seen; c++) begin
            if (busy_b) bc++;
            if (done_b) seen = 1'b1;
            if (scl_b != pscl) begin
                if (fell && nruns < 4) begin
                    lens[nruns] = runlen;
                    nruns++;
                end
                if (pscl && !scl_b) fell = 1'b1;
                runlen = 1;
            end else begin
                runlen++;
            end
            if (pscl && scl_b && (poe != sda_oe_b)) begin
                if (sda_oe_b) starts++;
                else stops++;
            end
            pscl = scl_b; poe = sda_oe_b;
            if (!seen) @(negedge clk);
        end
        n_cmp += 5;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL t250_done: got %b expected 1", seen); end
        if (lens[0] !== 125 || lens[2] !== 125) begin
            n_fail++; $display("FAIL t250_scl_low: got %0d/%0d expected 125/125", lens[0], lens[2]);
        end
        if (lens[1] !== 125 || lens[3] !== 125) begin
            n_fail++; $display("FAIL t250_scl_high: got %0d/%0d expected 125/125", lens[1], lens[3]);
        end
        if (starts !== 1 || stops !== 1) begin
            n_fail++; $display("FAIL t250_sda_while_scl_high: got %0d/%0d expected 1/1", starts, stops);
        end
        if (bc !== 5000) begin n_fail++; $display("FAIL t250_busy_cycles: got %0d expected 5000", bc); end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; addr_a = '0; data_a = '0; sda_in_a = 1'b0;
        start_b = 1'b0; addr_b = '0; data_b = '0; sda_in_b = 1'b0;
        test_reset();
        test_full_write();
        test_addr_nack();
        test_data_nack();
        test_reset_mid_data();
        test_repulse();
        test_back_to_back();
        test_timing_250();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
